// File: rtl/strela_stream_reader.sv
// Multi-channel strided stream reader: fetches N_CH word streams over one in-order
// read port, buffers each stream in a credit-controlled FIFO and hands words to the CGRA.
module strela_stream_reader #(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  input  logic [N_CH*16-1:0]       ch_size_i,
  input  logic [N_CH*16-1:0]       ch_stride_i,
  output logic [ADDR_W-1:0]        req_addr_o,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  input  logic [DATA_W-1:0]        rsp_data_i,
  input  logic                     rsp_valid_i,
  output logic                     rsp_ready_o,
  output logic [N_CH*DATA_W-1:0]   data_o,
  output logic [N_CH-1:0]          data_valid_o,
  input  logic [N_CH-1:0]          data_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [31:0]              stall_cycles_o
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FP_W = $clog2(FIFO_DEPTH);
  localparam int FC_W = FP_W + 1;
  localparam int TP_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TC_W = $clog2(MAX_OUTST) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q   [N_CH];
  logic [15:0]       size_q   [N_CH];
  logic [15:0]       stride_q [N_CH];
  logic [15:0]       issued_q [N_CH];
  logic [15:0]       deliv_q  [N_CH];
  logic [FC_W-1:0]   fcnt_q   [N_CH];
  logic [FC_W-1:0]   outst_q  [N_CH];
  logic [FP_W-1:0]   frd_q    [N_CH];
  logic [FP_W-1:0]   fwr_q    [N_CH];
  logic [DATA_W-1:0] fmem     [N_CH][FIFO_DEPTH];

  logic [CH_W-1:0]   tag_mem [MAX_OUTST];
  logic [TP_W-1:0]   tag_rd_q, tag_wr_q;
  logic [TC_W-1:0]   tag_cnt_q;

  logic              hold_q;
  logic [CH_W-1:0]   held_ch_q, rr_q;

  logic [N_CH-1:0]   elig, push, pop;
  logic [CH_W-1:0]   grant, req_ch, rsp_ch;
  logic              found, tag_full, pending, all_done, stall_cond, flush;
  logic              req_fire, rsp_fire, launch;
  int unsigned       idx;

  always_comb begin
    tag_full    = (tag_cnt_q == TC_W'(MAX_OUTST));
    rsp_ready_o = (tag_cnt_q != '0);
    rsp_ch      = tag_mem[tag_rd_q];
    rsp_fire    = rsp_valid_i && rsp_ready_o;
    all_done    = 1'b1;
    pending     = 1'b0;
    data_o      = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      // Credits count words already buffered plus words still in flight.
      elig[c] = (state_q == RUN) && (issued_q[c] < size_q[c]) && !tag_full &&
                (({1'b0, fcnt_q[c]} + {1'b0, outst_q[c]}) < (FC_W+1)'(FIFO_DEPTH));
      if (issued_q[c] < size_q[c]) pending = 1'b1;
      if (deliv_q[c] != size_q[c]) all_done = 1'b0;
      data_valid_o[c] = (fcnt_q[c] != '0);
      if (data_valid_o[c]) data_o[c*DATA_W +: DATA_W] = fmem[c][frd_q[c]];
      pop[c]  = data_valid_o[c] && data_ready_i[c];
      push[c] = rsp_fire && (state_q == RUN) && (rsp_ch == CH_W'(c));
    end
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = (32'(rr_q) + k) % N_CH;
      if (!found && elig[CH_W'(idx)]) begin
        found = 1'b1;
        grant = CH_W'(idx);
      end
    end
    req_valid_o = (state_q == RUN) && (hold_q || found);
    req_ch      = hold_q ? held_ch_q : grant;
    req_addr_o  = req_valid_o ? addr_q[req_ch] : '0;
    req_fire    = req_valid_o && req_ready_i;
    stall_cond  = (req_valid_o && !req_ready_i) || (pending && tag_full);
    launch      = (state_q == IDLE) && start_i;
    busy_o      = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      IDLE:  if (start_i) state_d = RUN;
      RUN:   if (abort_i) state_d = DRAIN;
             else if (all_done) state_d = IDLE;
      DRAIN: if (tag_cnt_q == '0) begin
               state_d = IDLE;
               flush   = 1'b1;
             end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      done_o         <= 1'b0;
      hold_q         <= 1'b0;
      held_ch_q      <= '0;
      rr_q           <= '0;
      tag_rd_q       <= '0;
      tag_wr_q       <= '0;
      tag_cnt_q      <= '0;
      stall_cycles_o <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        addr_q[c]   <= '0;
        size_q[c]   <= '0;
        stride_q[c] <= '0;
        issued_q[c] <= '0;
        deliv_q[c]  <= '0;
        fcnt_q[c]   <= '0;
        outst_q[c]  <= '0;
        frd_q[c]    <= '0;
        fwr_q[c]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      done_o    <= (state_q == RUN) && (state_d == IDLE);
      hold_q    <= req_valid_o && !req_ready_i;
      held_ch_q <= req_ch;

      if (req_fire) tag_wr_q <= (tag_wr_q == TP_W'(MAX_OUTST-1)) ? '0 : tag_wr_q + 1'b1;
      if (rsp_fire) tag_rd_q <= (tag_rd_q == TP_W'(MAX_OUTST-1)) ? '0 : tag_rd_q + 1'b1;
      tag_cnt_q <= tag_cnt_q + TC_W'(req_fire) - TC_W'(rsp_fire);

      if (launch) begin
        rr_q           <= '0;
        stall_cycles_o <= '0;
      end else begin
        if (req_fire) rr_q <= (req_ch == CH_W'(N_CH-1)) ? '0 : req_ch + 1'b1;
        if (state_q == RUN && stall_cond && stall_cycles_o != '1)
          stall_cycles_o <= stall_cycles_o + 32'd1;
      end

      for (int unsigned c = 0; c < N_CH; c++) begin
        if (launch) begin
          addr_q[c]   <= ch_addr_i[c*ADDR_W +: ADDR_W];
          size_q[c]   <= ch_size_i[c*16 +: 16];
          stride_q[c] <= ch_stride_i[c*16 +: 16];
          issued_q[c] <= '0;
          deliv_q[c]  <= '0;
        end else begin
          if (req_fire && req_ch == CH_W'(c)) begin
            addr_q[c]   <= addr_q[c] + ADDR_W'(stride_q[c]);
            issued_q[c] <= issued_q[c] + 16'd1;
          end
          if (pop[c]) deliv_q[c] <= deliv_q[c] + 16'd1;
        end
        outst_q[c] <= outst_q[c] + FC_W'(req_fire && req_ch == CH_W'(c))
                                 - FC_W'(rsp_fire && rsp_ch == CH_W'(c));
        if (flush) begin
          fcnt_q[c] <= '0;
          frd_q[c]  <= '0;
          fwr_q[c]  <= '0;
        end else begin
          if (push[c]) fwr_q[c] <= fwr_q[c] + 1'b1;
          if (pop[c])  frd_q[c] <= frd_q[c] + 1'b1;
          fcnt_q[c] <= fcnt_q[c] + FC_W'(push[c]) - FC_W'(pop[c]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_fire) tag_mem[tag_wr_q] <= req_ch;
    for (int unsigned c = 0; c < N_CH; c++)
      if (push[c]) fmem[c][fwr_q[c]] <= rsp_data_i;
  end

endmodule

// File: tb/tb_strela_stream_reader.sv
// Bench for strela_stream_reader: in-order memory model, per-channel output scoreboard
// and request-order queue, one task per scenario.
module tb_strela_stream_reader;
  localparam int N_CH = 4, DATA_W = 32, ADDR_W = 32;

  logic                   clk_i = 1'b0, rst_ni, start_i, abort_i;
  logic [N_CH*ADDR_W-1:0] ch_addr_i;
  logic [N_CH*16-1:0]     ch_size_i, ch_stride_i;
  logic [ADDR_W-1:0]      req_addr_o;
  logic                   req_valid_o, req_ready_i;
  logic [DATA_W-1:0]      rsp_data_i;
  logic                   rsp_valid_i, rsp_ready_o;
  logic [N_CH*DATA_W-1:0] data_o;
  logic [N_CH-1:0]        data_valid_o, data_ready_i;
  logic                   busy_o, done_o;
  logic [31:0]            stall_cycles_o;

  strela_stream_reader #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                         .FIFO_DEPTH(4), .MAX_OUTST(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .ch_addr_i(ch_addr_i), .ch_size_i(ch_size_i), .ch_stride_i(ch_stride_i),
    .req_addr_o(req_addr_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .rsp_data_i(rsp_data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .busy_o(busy_o), .done_o(done_o), .stall_cycles_o(stall_cycles_o));

  always #5 clk_i = ~clk_i;

  typedef struct { int unsigned ch; logic [31:0] data; } sb_t;
  sb_t         sb[$];
  logic [31:0] exp_req[$];
  logic [31:0] pend[$];
  bit          chk_req = 1'b0;
  bit          rsp_en  = 1'b1;
  int          n_cmp = 0, n_err = 0;
  int          done_cnt = 0, req_total = 0;
  int          req_ch_cnt[N_CH];
  int          del_cnt[N_CH];
  logic [31:0] cfg_base[N_CH];
  logic [15:0] cfg_size[N_CH], cfg_stride[N_CH];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic apply_cfg(input bit push_sb);
    sb_t e;
    for (int unsigned c = 0; c < N_CH; c++) begin
      ch_addr_i[c*32 +: 32]   = cfg_base[c];
      ch_size_i[c*16 +: 16]   = cfg_size[c];
      ch_stride_i[c*16 +: 16] = cfg_stride[c];
      req_ch_cnt[c] = 0;
      del_cnt[c]    = 0;
      if (push_sb)
        for (int unsigned i = 0; i < cfg_size[c]; i++) begin
          e.ch = c;
          e.data = memf(cfg_base[c] + i * 32'(cfg_stride[c]));
          sb.push_back(e);
        end
    end
  endtask

  task automatic start_run();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // Memory: accepts every request handshake, answers in order one cycle later.
  initial begin
    logic [31:0] a;
    bit req_hs, rsp_hs;
    rsp_valid_i = 1'b0; rsp_data_i = '0;
    forever begin
      @(negedge clk_i);
      req_hs = req_valid_o && req_ready_i && rst_ni;
      rsp_hs = rsp_valid_i && rsp_ready_o && rst_ni;
      a = req_addr_o;
      @(posedge clk_i); #1;
      if (rsp_hs && pend.size() > 0) void'(pend.pop_front());
      if (req_hs) pend.push_back(a);
      rsp_valid_i = rsp_en && (pend.size() > 0);
      rsp_data_i  = (pend.size() > 0) ? memf(pend[0]) : '0;
    end
  end

  // Output scoreboard and request-order monitor.
  initial begin
    logic [31:0] ra, er, od;
    int hit;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (done_o) done_cnt++;
        if (req_valid_o && req_ready_i) begin
          ra = req_addr_o;
          req_total++;
          req_ch_cnt[ra[25:24]]++;
          if (chk_req) begin
            n_cmp++;
            if (exp_req.size() == 0) begin
              n_err++; $display("FAIL req_order: got %h, required no request", ra);
            end else begin
              er = exp_req.pop_front();
              if (ra !== er) begin
                n_err++; $display("FAIL req_order: got %h, required %h", ra, er);
              end
            end
          end
        end
        for (int unsigned c = 0; c < N_CH; c++)
          if (data_valid_o[c] && data_ready_i[c]) begin
            od = data_o[c*DATA_W +: DATA_W];
            del_cnt[c]++;
            hit = -1;
            for (int i = 0; i < sb.size(); i++)
              if (sb[i].ch == c) begin hit = i; break; end
            n_cmp++;
            if (hit < 0) begin
              n_err++; $display("FAIL sb_ch%0d: got %h, required no word", c, od);
            end else begin
              if (od !== sb[hit].data) begin
                n_err++; $display("FAIL sb_ch%0d: got %h, required %h", c, od, sb[hit].data);
              end
              sb.delete(hit);
            end
          end
      end
    end
  end

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; req_ready_i = 1'b1;
    data_ready_i = '1; ch_addr_i = '0; ch_size_i = '0; ch_stride_i = '0;
    repeat (3) tick();
    n_cmp++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b, required 0", req_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy_o); end
    n_cmp++; if (data_valid_o !== 4'h0) begin n_err++; $display("FAIL rst_data_valid: got %b, required 0000", data_valid_o); end
    n_cmp++; if (stall_cycles_o !== 32'd0) begin n_err++; $display("FAIL rst_stall: got %0d, required 0", stall_cycles_o); end
    n_cmp++; if (rsp_ready_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL rst_rsp_done: got %b%b, required 00", rsp_ready_o, done_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_rr_interleave();
    bit ok; int d0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      cfg_base[c] = 32'h8000_0000 + (c << 24); cfg_size[c] = 16'd8; cfg_stride[c] = 16'd4;
    end
    apply_cfg(1'b1);
    for (int unsigned i = 0; i < 8; i++)
      for (int unsigned c = 0; c < N_CH; c++) exp_req.push_back(cfg_base[c] + 4 * i);
    chk_req = 1'b1; d0 = done_cnt;
    start_run();
    wait_idle(200, ok);
    repeat (3) tick();
    chk_req = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_timeout: got busy, required idle"); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL rr_done_pulses: got %0d, required 1", done_cnt - d0); end
    n_cmp++; if (stall_cycles_o !== 32'd0) begin n_err++; $display("FAIL rr_stall: got %0d, required 0", stall_cycles_o); end
    n_cmp++; if (sb.size() != 0 || exp_req.size() != 0) begin n_err++; $display("FAIL rr_leftover: got %0d/%0d, required 0/0", sb.size(), exp_req.size()); end
  endtask

  task automatic test_backpressure();
    bit ok; int d0;
    apply_cfg(1'b1);
    data_ready_i = 4'b1101; d0 = done_cnt;
    start_run();
    repeat (80) tick();
    n_cmp++; if (req_ch_cnt[1] != 4) begin n_err++; $display("FAIL bp_ch1_reqs: got %0d, required 4", req_ch_cnt[1]); end
    for (int c = 0; c < N_CH; c++)
      if (c != 1) begin
        n_cmp++; if (del_cnt[c] != 8) begin n_err++; $display("FAIL bp_deliv_ch%0d: got %0d, required 8", c, del_cnt[c]); end
      end
    n_cmp++; if (busy_o !== 1'b1 || done_cnt != d0) begin n_err++; $display("FAIL bp_early_done: got busy=%b done=%0d, required busy=1 done=0", busy_o, done_cnt - d0); end
    data_ready_i = 4'b1111;
    wait_idle(200, ok);
    repeat (3) tick();
    n_cmp++; if (!ok || done_cnt - d0 != 1) begin n_err++; $display("FAIL bp_done: got %0d pulses, required 1", done_cnt - d0); end
    n_cmp++; if (req_ch_cnt[1] != 8) begin n_err++; $display("FAIL bp_ch1_total: got %0d, required 8", req_ch_cnt[1]); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_req_stall();
    bit ok;
    for (int unsigned c = 0; c < N_CH; c++) begin cfg_base[c] = '0; cfg_size[c] = '0; cfg_stride[c] = '0; end
    cfg_base[0] = 32'h4000_0000; cfg_size[0] = 16'd8; cfg_stride[0] = 16'd8;
    apply_cfg(1'b1);
    start_run();
    tick(); tick();
    req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (req_valid_o !== 1'b1 || req_addr_o !== 32'h4000_0010) begin
        n_err++; $display("FAIL stall_hold: got %b/%h, required 1/40000010", req_valid_o, req_addr_o);
      end
      tick();
    end
    req_ready_i = 1'b1;
    wait_idle(200, ok);
    tick();
    n_cmp++; if (!ok || stall_cycles_o !== 32'd5) begin n_err++; $display("FAIL stall_count: got %0d, required 5", stall_cycles_o); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_leftover: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    cfg_base[0] = 32'hFFFF_FFF8; cfg_size[0] = 16'd3; cfg_stride[0] = 16'hFFFC;
    apply_cfg(1'b1);
    exp_req.push_back(32'hFFFF_FFF8);
    exp_req.push_back(32'h0000_FFF4);
    exp_req.push_back(32'h0001_FFF0);
    chk_req = 1'b1;
    start_run();
    wait_idle(100, ok);
    repeat (2) tick();
    chk_req = 1'b0;
    n_cmp++; if (!ok || exp_req.size() != 0) begin n_err++; $display("FAIL wrap_reqs: got %0d left, required 0", exp_req.size()); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL wrap_leftover: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_abort();
    bit ok; int d0, r0;
    cfg_base[0] = 32'h2000_0000; cfg_size[0] = 16'd8; cfg_stride[0] = 16'd4;
    apply_cfg(1'b0);
    rsp_en = 1'b0; d0 = done_cnt; r0 = req_total;
    start_run();
    tick(); tick(); tick();
    req_ready_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0; req_ready_i = 1'b1;
    n_cmp++; if (req_total - r0 != 3 || pend.size() != 3) begin n_err++; $display("FAIL abort_outst: got %0d/%0d, required 3/3", req_total - r0, pend.size()); end
    @(negedge clk_i);
    n_cmp++; if (req_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL abort_drain: got valid=%b busy=%b, required 0/1", req_valid_o, busy_o); end
    tick(); tick();
    rsp_en = 1'b1;
    wait_idle(60, ok);
    repeat (3) tick();
    n_cmp++; if (!ok) begin n_err++; $display("FAIL abort_busy: got busy, required idle"); end
    n_cmp++; if (pend.size() != 0 || req_total - r0 != 3) begin n_err++; $display("FAIL abort_rsp: got %0d pending %0d reqs, required 0/3", pend.size(), req_total - r0); end
    n_cmp++; if (done_cnt != d0 || data_valid_o !== 4'h0) begin n_err++; $display("FAIL abort_done: got %0d/%b, required 0/0000", done_cnt - d0, data_valid_o); end
    for (int unsigned c = 0; c < N_CH; c++) begin
      cfg_base[c] = 32'h1000_0000 + (c << 24); cfg_size[c] = 16'd2; cfg_stride[c] = 16'd4;
    end
    apply_cfg(1'b1);
    start_run();
    wait_idle(100, ok);
    repeat (3) tick();
    n_cmp++; if (!ok || done_cnt - d0 != 1 || sb.size() != 0) begin n_err++; $display("FAIL abort_rerun: got %0d done %0d left, required 1/0", done_cnt - d0, sb.size()); end
  endtask

  task automatic test_zero_and_reset();
    int d0, r0;
    for (int unsigned c = 0; c < N_CH; c++) cfg_size[c] = '0;
    apply_cfg(1'b0);
    d0 = done_cnt; r0 = req_total;
    start_run();
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b1 || done_o !== 1'b0 || req_valid_o !== 1'b0) begin n_err++; $display("FAIL zero_c1: got busy=%b done=%b valid=%b, required 1/0/0", busy_o, done_o, req_valid_o); end
    tick();
    @(negedge clk_i);
    n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL zero_c2: got done=%b busy=%b, required 1/0", done_o, busy_o); end
    tick();
    n_cmp++; if (req_total != r0 || done_cnt - d0 != 1) begin n_err++; $display("FAIL zero_reqs: got %0d reqs %0d done, required 0/1", req_total - r0, done_cnt - d0); end
    for (int unsigned c = 0; c < N_CH; c++) begin
      cfg_base[c] = 32'h8000_0000 + (c << 24); cfg_size[c] = 16'd8; cfg_stride[c] = 16'd4;
    end
    apply_cfg(1'b1);
    start_run();
    repeat (5) tick();
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (req_valid_o !== 1'b0 || req_addr_o !== 32'd0 || rsp_ready_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_req: got %b/%h/%b, required 0/0/0", req_valid_o, req_addr_o, rsp_ready_o); end
    n_cmp++; if (data_valid_o !== 4'h0 || data_o !== '0) begin n_err++; $display("FAIL mid_rst_data: got %b/%h, required 0/0", data_valid_o, data_o); end
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0 || stall_cycles_o !== 32'd0) begin n_err++; $display("FAIL mid_rst_status: got %b/%b/%0d, required 0/0/0", busy_o, done_o, stall_cycles_o); end
    tick(); tick();
    pend.delete(); sb.delete();
    rst_ni = 1'b1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_rr_interleave();
    test_backpressure();
    test_req_stall();
    test_addr_wrap();
    test_abort();
    test_zero_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end
endmodule

// File: doc/strela_stream_reader.md
Name: strela_stream_reader

Overview:
- Parametrised, multi-channel successor to the fixed 4-channel input-stream engine that feeds the CGRA.
- Fetches N_CH independent strided word streams from memory over a single in-order read-request/response port.
- Arbitrates channels round-robin and buffers each stream in a per-channel FIFO with credit control.
- Delivers each stream to the CGRA input nodes on valid/ready handshakes; adds abort and stall-cycle counting.

Parameters:
- N_CH, 4, number of input channels (1..16)
- DATA_W, 32, word width; memory and CGRA data width
- ADDR_W, 32, byte address width
- FIFO_DEPTH, 4, per-channel data FIFO entries (power of 2, >=2)
- MAX_OUTST, 4, maximum in-flight read requests (power of 2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; launches all channels (accepted only in IDLE)
- abort_i  in  1  one-cycle pulse; cancels the running transfer
- ch_addr_i  in  N_CH*ADDR_W  per-channel base byte address
- ch_size_i  in  N_CH*16  per-channel word count
- ch_stride_i  in  N_CH*16  per-channel byte stride, unsigned
- req_addr_o  out  ADDR_W  read request address
- req_valid_o  out  1  read request valid
- req_ready_i  in  1  read request accepted
- rsp_data_i  in  DATA_W  read response data, returned in request order
- rsp_valid_i  in  1  response valid
- rsp_ready_o  out  1  response accept
- data_o  out  N_CH*DATA_W  per-channel word to the CGRA
- data_valid_o  out  N_CH  per-channel valid
- data_ready_i  in  N_CH  per-channel ready from the CGRA
- busy_o  out  1  high in RUN or DRAIN
- done_o  out  1  one-cycle pulse on normal completion
- stall_cycles_o  out  32  RUN cycles with a pending request blocked

Behaviour:
- Reset: state IDLE; all outputs 0; FIFOs and the tag FIFO empty; counters 0; round-robin pointer 0.

State machine:
- IDLE -> RUN on start_i. On that edge, latch the addr, size and stride of every channel, clear stall_cycles_o and reset the RR pointer to 0.
- RUN -> IDLE when every channel has delivered size words on the CGRA handshake. done_o pulses for one cycle on that transition.
- A start with all sizes 0 goes IDLE -> RUN -> IDLE: done_o pulses on the second cycle after start_i, and no request is issued.
- RUN -> DRAIN on abort_i. DRAIN -> IDLE once the outstanding count reaches 0. done_o is not pulsed on this path.
- start_i outside IDLE is ignored. abort_i in IDLE or DRAIN is ignored.

Request eligibility and issue:
- A channel is eligible when issued < size AND (fifo_count + outstanding_ch) < FIFO_DEPTH AND the tag FIFO is not full.
- The RR grant goes to the first eligible channel at or after the pointer.
- The request is held stable (addr, channel) while req_valid_o && !req_ready_i. A newly eligible channel cannot preempt it.
- On the request handshake: push the channel index into the tag FIFO; the channel's address += stride (modulo 2^ADDR_W, wraps silently); issued++; the pointer becomes grant+1 modulo N_CH.

Responses and output:
- rsp_ready_o = tag FIFO non-empty. Data is pushed into the FIFO of the head tag channel; credits guarantee space.
- In DRAIN, responses are accepted and discarded, and no requests are issued.
- data_o and data_valid_o come from the FIFO head; a word leaves on valid && ready.
- FIFO write and read in the same cycle: the count is unchanged. A full FIFO with simultaneous pop and push must not lose data.
- FIFO contents are flushed on entry to IDLE from DRAIN.

Stall counter:
- stall_cycles_o increments in RUN each cycle where req_valid_o && !req_ready_i, or where some channel has issued < size but the tag FIFO is full.
- Saturates at 2^32-1.

Latency: first request is valid 1 cycle after start_i; a response word is visible on data_o 1 cycle after the response handshake.

Test Plan:
- N_CH=4, sizes 8, strides 4, bases 0x80000000/0x81000000/0x82000000/0x83000000, memory always ready, 1-cycle response -> request addresses interleave ch0,ch1,ch2,ch3 in RR order; each channel outputs 8 words from consecutive addresses; done_o pulses once; stall_cycles_o=0.
- ch1 data_ready_i held 0, size 8 -> ch1 issues exactly FIFO_DEPTH=4 requests then stops; other channels complete their words; releasing ready completes ch1 and done fires.
- req_ready_i low 5 cycles during RUN -> req_addr_o stable throughout; stall_cycles_o=5.
- Stride 0xFFFC, base 0xFFFFFFF8, size 3 -> addresses 0xFFFFFFF8, 0x0000FFF4, 0x0001FFF0 (wraps modulo 2^32).
- abort_i with 3 requests outstanding -> no new requests; 3 responses are consumed and discarded; busy_o drops; done_o stays 0; the next start_i runs normally.
- All sizes 0 -> no request issued; done_o pulses on the second cycle after start_i; rst_ni asserted mid-RUN -> all outputs 0 immediately.
